// File: rtl/pair_run_logger.sv
// pair_run_logger: run-length statistics on the pair detector output with clear-on-read snapshot handshake
module pair_run_logger #(
    parameter int CNT_W     = 8,
    parameter int ALARM_RUN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_z,
    input  logic             i_rd_req,
    output logic             o_rd_ack,
    output logic [CNT_W-1:0] o_snap_events,
    output logic [CNT_W-1:0] o_snap_runs,
    output logic [CNT_W-1:0] o_snap_max,
    output logic             o_snap_alarm,
    output logic [CNT_W-1:0] o_cur_run,
    output logic [1:0]       o_state
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_LONG = 2'd2, S_BAD = 2'd3} state_t;

    localparam logic [CNT_W-1:0] ALARM_V = CNT_W'(ALARM_RUN);
    localparam logic [CNT_W-1:0] SAT     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           r_state, w_state_n;
    logic [CNT_W-1:0] r_cur, r_ev, r_runs, r_mx;
    logic             r_alm, r_rd_ack;
    logic [CNT_W-1:0] r_snap_ev, r_snap_runs, r_snap_mx;
    logic             r_snap_alm;
    logic [CNT_W-1:0] w_cur_n, w_ev_n, w_runs_n, w_mx_n;
    logic             w_alm_n, w_long, w_capture;

    // Values every register would take on this edge before any capture clears the accumulators
    always_comb begin
        w_cur_n   = i_z ? ((r_cur == SAT) ? r_cur : r_cur + ONE) : '0;
        w_long    = w_cur_n >= ALARM_V;
        w_ev_n    = (i_z && r_ev != SAT) ? r_ev + ONE : r_ev;
        w_runs_n  = (i_z && r_state == S_IDLE && r_runs != SAT) ? r_runs + ONE : r_runs;
        w_mx_n    = (w_cur_n > r_mx) ? w_cur_n : r_mx;
        w_alm_n   = r_alm | w_long;
        w_capture = i_rd_req & ~r_rd_ack;
        w_state_n = S_IDLE;
        case (r_state)
            S_IDLE, S_RUN: w_state_n = i_z ? (w_long ? S_LONG : S_RUN) : S_IDLE;
            S_LONG:        w_state_n = i_z ? S_LONG : S_IDLE;
            default:       w_state_n = S_IDLE;
        endcase
    end

    // Run tracking, live accumulators, snapshot capture and acknowledge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cur       <= '0;
            r_ev        <= '0;
            r_runs      <= '0;
            r_mx        <= '0;
            r_alm       <= 1'b0;
            r_rd_ack    <= 1'b0;
            r_snap_ev   <= '0;
            r_snap_runs <= '0;
            r_snap_mx   <= '0;
            r_snap_alm  <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_cur    <= w_cur_n;
            r_rd_ack <= i_rd_req;
            r_ev     <= w_capture ? '0 : w_ev_n;
            r_runs   <= w_capture ? '0 : w_runs_n;
            r_mx     <= w_capture ? '0 : w_mx_n;
            r_alm    <= w_capture ? 1'b0 : w_alm_n;
            if (w_capture) begin
                r_snap_ev   <= w_ev_n;
                r_snap_runs <= w_runs_n;
                r_snap_mx   <= w_mx_n;
                r_snap_alm  <= w_alm_n;
            end
        end
    end

    assign o_rd_ack      = r_rd_ack;
    assign o_snap_events = r_snap_ev;
    assign o_snap_runs   = r_snap_runs;
    assign o_snap_max    = r_snap_mx;
    assign o_snap_alarm  = r_snap_alm;
    assign o_cur_run     = r_cur;
    assign o_state       = r_state;
endmodule

// File: doc/pair_run_logger.md
# pair_run_logger

Statistics stage directly downstream of the two-consecutive-ones Mealy detector. It samples the detector's `z` output every clock and tracks the current run length of `z`. It accumulates event count, run count and longest run, and raises a sticky alarm when a run reaches a threshold. A four-phase read handshake snapshots all statistics atomically and clears the live accumulators (clear-on-read).

## Interface
- `CNT_W`, default 8: width of every counter; all counters saturate at 2^CNT_W−1.
- `ALARM_RUN`, default 4: run length (cycles of `z`=1) that sets the alarm; legal range 1..2^CNT_W−1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, asynchronous, active-low.
- `z`  in  1  detector output, sampled on every rising edge of `clk`.
- `rd_req`  in  1  read request, level, four-phase.
- `rd_ack`  out  1  read acknowledge, registered.
- `snap_events`  out  CNT_W  captured count of cycles with `z`=1.
- `snap_runs`  out  CNT_W  captured count of runs (0→1 transitions of sampled `z`).
- `snap_max`  out  CNT_W  captured longest run.
- `snap_alarm`  out  1  captured sticky alarm.
- `cur_run`  out  CNT_W  live length of the current run; 0 when the last sampled `z` was 0.
- `state`  out  2  live FSM state: IDLE=0, RUN=1, LONG=2.

## Operation
- FSM, evaluated on each edge using sampled `z`:
  - IDLE: `z`=1 goes to RUN, or to LONG if ALARM_RUN=1. `z`=0 stays in IDLE.
  - RUN: `z`=1 stays in RUN until the new `cur_run` ≥ ALARM_RUN, then goes to LONG. `z`=0 goes to IDLE.
  - LONG: `z`=1 stays in LONG. `z`=0 goes to IDLE.
  - Code 3 is unreachable and recovers to IDLE on the next edge.
- `cur_run`:
  - `z`=1: `cur_run` becomes min(`cur_run`+1, max).
  - `z`=0: `cur_run` becomes 0.
- Live accumulators are internal: `ev`, `runs`, `mx`, `alm`.
  - `z`=1: `ev` increments, saturating.
  - `z`=1 while in IDLE: `runs` increments, saturating.
  - `mx` becomes max(`mx`, new `cur_run`).
  - `alm` is set when the new `cur_run` ≥ ALARM_RUN and stays set until a capture.
- Capture: occurs on an edge where `rd_req`=1 and `rd_ack`=0.
  - `snap_*` load the live values as updated by that same edge, so the current `z` is included.
  - Live `ev`, `runs`, `mx` and `alm` load 0. The current cycle is not counted again.
  - `cur_run` and `state` are not affected. A run in progress continues, and from the next edge `mx` and `alm` track it again from its full `cur_run`.
- Handshake:
  - `rd_ack` rises on the capture edge.
  - `rd_ack` stays 1 while `rd_req`=1.
  - `rd_ack` falls on the first edge that samples `rd_req`=0.
  - A new capture requires `rd_req` to be sampled low with `rd_ack` low first. Holding `rd_req` high yields exactly one capture.
- `snap_*` hold their values between captures.

## Timing
- Reset value of every output and internal register is 0: `state`=IDLE, `rd_ack`=0, `snap_*`=0, `cur_run`=0. Reset takes effect immediately, without waiting for a clock edge.
- Reset mid-run or mid-handshake discards all statistics and snapshots.
- Latency from sampled `z` to `cur_run`/`state`: 1 edge.
- Latency from `rd_req` rising to `rd_ack` and `snap_*` valid: 1 edge. `snap_*` are valid in the same cycle that `rd_ack` is first seen high.
- `z` is a Mealy output. It comes combinationally from upstream state and input, and must be stable before the `clk` edge; this block adds no synchronizer.
- Saturation: a counter at its maximum holds that value. It never wraps to 0.
- Capture and `z`=1 on the same edge: the event goes into the snapshot only, never into both.

## Test plan
- Sequence:
  - Stimulus: reset, then `z` = 1,1,0,1,1,1,1,1,0, one value per cycle, followed by a read.
  - Required response: `snap_events`=7, `snap_runs`=2, `snap_max`=5, `snap_alarm`=1.
  - Live counters are 0 after the read.
  - `state` sequence is RUN,RUN,IDLE,RUN,RUN,RUN,LONG,LONG,IDLE.
- Saturation:
  - Stimulus: hold `z`=1 for 300 cycles, then read.
  - Required response: `cur_run`=255, `snap_events`=255, `snap_max`=255, `snap_runs`=1.
- Capture during a run:
  - Stimulus: `z`=1 for 3 cycles, capture on the 3rd edge, then `z`=1 for 2 more cycles, `z`=0, then read again.
  - First snapshot: `snap_events`=3, `snap_max`=3, `snap_alarm`=0.
  - Second snapshot: `snap_events`=2, `snap_runs`=0, `snap_max`=5, `snap_alarm`=1.
- Handshake:
  - Stimulus: hold `rd_req`=1 for 10 cycles while `z` toggles.
  - Required response: exactly one capture. `snap_*` are unchanged after the first `rd_ack` edge. `rd_ack` falls exactly 1 edge after `rd_req` is sampled low.
- Asynchronous reset:
  - Stimulus: assert `reset`=0 between clock edges in LONG with `rd_ack`=1.
  - Required response: all outputs are 0 immediately, and the next capture reports only post-reset activity.
